alu_reservation_station: RTL

//  Holds decoded ALU/branch instructions until both source operands are known, then issues one per

---
 rtl/alu_reservation_station_pkg.sv | 66 ++++++
 rtl/rs_priority_picker.sv | 22 ++
 rtl/alu_reservation_station.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_reservation_station_pkg.sv
// Shared widths, opcode encodings and entry/operand types for the ALU reservation station.
// The station passes opcodes through untouched; the encodings are here so benches and neighbours agree.
package alu_reservation_station_pkg;

  localparam int RS_SIZE    = 16;
  localparam int IDX_WIDTH  = 4;
  localparam int TAG_WIDTH  = 4;
  localparam int DATA_WIDTH = 32;
  localparam int OP_WIDTH   = 6;
  localparam int PC_WIDTH   = 32;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_NOP = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } alu_op_e;

  typedef struct packed {
    logic [OP_WIDTH-1:0]   op;
    logic [DATA_WIDTH-1:0] v1;
    logic [TAG_WIDTH-1:0]  q1;
    logic                  r1;
    logic [DATA_WIDTH-1:0] v2;
    logic [TAG_WIDTH-1:0]  q2;
    logic                  r2;
    logic [DATA_WIDTH-1:0] imm;
    logic [PC_WIDTH-1:0]   pc;
    logic [TAG_WIDTH-1:0]  tag;
  } rs_entry_t;

  typedef struct packed {
    logic                  ready;
    logic [DATA_WIDTH-1:0] value;
  } operand_t;

  // Resolve one operand against both CDBs; an already-ready operand is returned unchanged.
  function automatic operand_t snoop_operand(
    input logic                  ready,
    input logic [DATA_WIDTH-1:0] value,
    input logic [TAG_WIDTH-1:0]  q,
    input logic                  alu_valid,
    input logic [TAG_WIDTH-1:0]  alu_tag,
    input logic [DATA_WIDTH-1:0] alu_data,
    input logic                  lsb_valid,
    input logic [TAG_WIDTH-1:0]  lsb_tag,
    input logic [DATA_WIDTH-1:0] lsb_data
  );
    operand_t res;
    res.ready = ready;
    res.value = value;
    if (!ready) begin
      if (alu_valid && alu_tag == q) begin
        res.ready = 1'b1;
        res.value = alu_data;
      end else if (lsb_valid && lsb_tag == q) begin
        res.ready = 1'b1;
        res.value = lsb_data;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rs_priority_picker.sv
// Lowest-index-first picker: reports whether any request bit is set and the index of the lowest one.
module rs_priority_picker
  import alu_reservation_station_pkg::*;
#(
  parameter int N = RS_SIZE,
  parameter int W = IDX_WIDTH
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  always_comb begin
    // NOTE: every output gets a default before the loop, so no latch is inferred when req is zero.
    found = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched instructions, wakes operands from both CDBs,
// and issues the lowest-index ready entry to the ALU each cycle. Flush discards everything.
module alu_reservation_station
  import alu_reservation_station_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_from_dsp,
  input  logic [OP_WIDTH-1:0]   op_from_dsp,
  input  logic [DATA_WIDTH-1:0] v1_from_dsp,
  input  logic [TAG_WIDTH-1:0]  q1_from_dsp,
  input  logic                  q1_busy_from_dsp,
  input  logic [DATA_WIDTH-1:0] v2_from_dsp,
  input  logic [TAG_WIDTH-1:0]  q2_from_dsp,
  input  logic                  q2_busy_from_dsp,
  input  logic [DATA_WIDTH-1:0] imm_from_dsp,
  input  logic [PC_WIDTH-1:0]   pc_from_dsp,
  input  logic [TAG_WIDTH-1:0]  tag_from_dsp,
  input  logic                  alu_cdb_valid,
  input  logic [TAG_WIDTH-1:0]  alu_cdb_tag,
  input  logic [DATA_WIDTH-1:0] alu_cdb_data,
  input  logic                  lsb_cdb_valid,
  input  logic [TAG_WIDTH-1:0]  lsb_cdb_tag,
  input  logic [DATA_WIDTH-1:0] lsb_cdb_data,
  input  logic                  flush_from_rob,
  output logic                  full_to_dsp,
  output logic [OP_WIDTH-1:0]   op_to_alu,
  output logic [DATA_WIDTH-1:0] v1_to_alu,
  output logic [DATA_WIDTH-1:0] v2_to_alu,
  output logic [DATA_WIDTH-1:0] imm_to_alu,
  output logic [PC_WIDTH-1:0]   pc_to_alu,
  output logic [TAG_WIDTH-1:0]  tag_to_alu,
  output logic                  is_empty_to_alu
);

  logic [RS_SIZE-1:0]   busy_q;
  logic [RS_SIZE-1:0]   ready_vec;
  rs_entry_t            entry_q [RS_SIZE];

  logic                 free_found;
  logic [IDX_WIDTH-1:0] free_idx;
  logic                 issue_found;
  logic [IDX_WIDTH-1:0] issue_idx;
  logic                 do_dispatch;
  logic                 do_issue;

  operand_t             new_op1;
  operand_t             new_op2;
  rs_entry_t            new_entry;

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy_q[i] & entry_q[i].r1 & entry_q[i].r2;
    end
  end

  rs_priority_picker #(.N(RS_SIZE), .W(IDX_WIDTH)) u_free_picker (
    .req   (~busy_q),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_priority_picker #(.N(RS_SIZE), .W(IDX_WIDTH)) u_issue_picker (
    .req   (ready_vec),
    .found (issue_found),
    .idx   (issue_idx)
  );

  assign full_to_dsp = ~free_found;
  assign do_dispatch = valid_from_dsp & ~full_to_dsp & ~flush_from_rob;
  assign do_issue    = issue_found & ~flush_from_rob;

  // Dispatch-time bypass: an operand whose producer broadcasts this very cycle is stored ready.
  always_comb begin
    new_op1 = snoop_operand(~q1_busy_from_dsp, v1_from_dsp, q1_from_dsp,
                            alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
                            lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data);
    new_op2 = snoop_operand(~q2_busy_from_dsp, v2_from_dsp, q2_from_dsp,
                            alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
                            lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data);
    new_entry     = '0;
    new_entry.op  = op_from_dsp;
    new_entry.v1  = new_op1.value;
    new_entry.q1  = q1_from_dsp;
    new_entry.r1  = new_op1.ready;
    new_entry.v2  = new_op2.value;
    new_entry.q2  = q2_from_dsp;
    new_entry.r2  = new_op2.ready;
    new_entry.imm = imm_from_dsp;
    new_entry.pc  = pc_from_dsp;
    new_entry.tag = tag_from_dsp;
  end

  // The issued slot is busy and the dispatch slot is free, so the two updates never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      busy_q <= '0;
    end else if (flush_from_rob) begin
      busy_q <= '0;
    end else begin
      if (do_issue)    busy_q[issue_idx] <= 1'b0;
      if (do_dispatch) busy_q[free_idx]  <= 1'b1;
    end
  end

  // NOTE: entry payload is not reset; it is only observed while its busy bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_SIZE; i++) begin
      if (do_dispatch && free_idx == IDX_WIDTH'(i)) begin
        entry_q[i] <= new_entry;
      end else if (busy_q[i]) begin
        entry_q[i].r1 <= snoop_operand(entry_q[i].r1, entry_q[i].v1, entry_q[i].q1,
                                       alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
                                       lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data).ready;
        entry_q[i].v1 <= snoop_operand(entry_q[i].r1, entry_q[i].v1, entry_q[i].q1,
                                       alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
                                       lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data).value;
        entry_q[i].r2 <= snoop_operand(entry_q[i].r2, entry_q[i].v2, entry_q[i].q2,
                                       alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
                                       lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data).ready;
        entry_q[i].v2 <= snoop_operand(entry_q[i].r2, entry_q[i].v2, entry_q[i].q2,
                                       alu_cdb_valid, alu_cdb_tag, alu_cdb_data,
                                       lsb_cdb_valid, lsb_cdb_tag, lsb_cdb_data).value;
      end
    end
  end

  // Issue register: fields hold their last value whenever nothing issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_to_alu       <= '0;
      v1_to_alu       <= '0;
      v2_to_alu       <= '0;
      imm_to_alu      <= '0;
      pc_to_alu       <= '0;
      tag_to_alu      <= '0;
      is_empty_to_alu <= 1'b1;
    end else if (do_issue) begin
      op_to_alu       <= entry_q[issue_idx].op;
      v1_to_alu       <= entry_q[issue_idx].v1;
      v2_to_alu       <= entry_q[issue_idx].v2;
      imm_to_alu      <= entry_q[issue_idx].imm;
      pc_to_alu       <= entry_q[issue_idx].pc;
      tag_to_alu      <= entry_q[issue_idx].tag;
      is_empty_to_alu <= 1'b0;
    end else begin
      is_empty_to_alu <= 1'b1;
    end
  end

endmodule
